// File: rtl/scaled_word_encoder_pkg.sv
// Shared constants, word layout and FSM state for the scaled-word encoder.
// Mantissa/scale widths and saturation limits live here.
package scaled_word_encoder_pkg;

  localparam int IN_W    = 32;
  localparam int IN_FRAC = 16;
  localparam int MANT_W  = 13;
  localparam int SCALE_W = 3;
  localparam int WORD_W  = MANT_W + SCALE_W;

  localparam int MANT_LSB = SCALE_W;
  localparam int MANT_MSB = WORD_W - 1;
  localparam int SCALE_MSB = SCALE_W - 1;

  localparam int signed MANT_MAX = 4095;
  localparam int signed MANT_MIN = -4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } enc_state_e;

endpackage

// File: rtl/scaled_word_encoder_if.sv
// Operand/result handshake bundle for the scaled-word encoder.
// slave: encoder side; master: producer + consumer side.
interface scaled_word_encoder_if;

  logic [scaled_word_encoder_pkg::IN_W-1:0]   in_data;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [scaled_word_encoder_pkg::WORD_W-1:0] out_word;
  logic                                       out_ovf;
  logic                                       out_inexact;
  logic                                       out_valid;
  logic                                       out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_word, out_ovf,
    output out_inexact, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_word, out_ovf,
    input  out_inexact, out_valid
  );

endinterface

// File: rtl/scaled_word_encoder_fit_check.sv
// Combinational fit test of one candidate scale: data_i, scale_i ->
// shifted mantissa mant_o, range flag fits_o, discarded-bits flag inexact_o.
module scaled_fit_check
  import scaled_word_encoder_pkg::*;
(
  input  logic [IN_W-1:0]    data_i,
  input  logic [SCALE_W-1:0] scale_i,
  output logic [MANT_W-1:0]  mant_o,
  output logic               fits_o,
  output logic               inexact_o
);

  logic [4:0]             sh;
  logic signed [IN_W-1:0] shifted;
  logic [IN_W-1:0]        mask;

  // Keeping s fractional bits means dropping IN_FRAC - s bits.
  assign sh      = 5'(IN_FRAC) - 5'(scale_i);
  assign shifted = $signed(data_i) >>> sh;
  assign mask    = (IN_W'(1) << sh) - IN_W'(1);

  assign fits_o    = (shifted >= MANT_MIN) && (shifted <= MANT_MAX);
  assign mant_o    = shifted[MANT_W-1:0];
  assign inexact_o = |(data_i & mask);

endmodule

// File: rtl/scaled_word_encoder.sv
// Serial Q16.16 -> {mantissa, scale} encoder, one scale tried per cycle.
// Ports: clk, rst (sync, active-high), bus (slave handshake bundle).
module scaled_word_encoder
  import scaled_word_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  scaled_word_encoder_if.slave bus
);

  enc_state_e         state_q, state_d;
  logic [IN_W-1:0]    op_q, op_d;
  logic [SCALE_W-1:0] s_q, s_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               ovf_q, ovf_d;
  logic               inx_q, inx_d;

  logic [MANT_W-1:0]  m_cand;
  logic               fits;
  logic               fit_inx;

  scaled_fit_check u_fit (
    .data_i    (op_q),
    .scale_i   (s_q),
    .mant_o    (m_cand),
    .fits_o    (fits),
    .inexact_o (fit_inx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      s_q     <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s_q     <= s_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      inx_q   <= inx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    s_d     = s_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    inx_d   = inx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          s_d     = '1;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (fits) begin
          word_d  = {m_cand, s_q};
          ovf_d   = 1'b0;
          inx_d   = fit_inx;
          state_d = ST_DONE;
        end else if (s_q == '0) begin
          // Still too big at s=0: clamp toward the operand's sign.
          word_d  = {op_q[IN_W-1] ? MANT_W'(MANT_MIN)
                                  : MANT_W'(MANT_MAX),
                     SCALE_W'(0)};
          ovf_d   = 1'b1;
          inx_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          s_d = s_q - SCALE_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state_q == ST_IDLE);
    bus.out_valid   = (state_q == ST_DONE);
    bus.out_word    = word_q;
    bus.out_ovf     = ovf_q;
    bus.out_inexact = inx_q;
  end

endmodule
